// File: rtl/zeroheti_pkg.sv
// Shared ZeroHeti address map and machine-timer register layout.
package zeroheti_pkg;

    localparam logic [31:0] MtimerBase = 32'h0000_A100;

    localparam logic [31:0] MtimeLoOffs    = 32'h00;
    localparam logic [31:0] MtimeHiOffs    = 32'h04;
    localparam logic [31:0] MtimecmpLoOffs = 32'h08;
    localparam logic [31:0] MtimecmpHiOffs = 32'h0C;
    localparam logic [31:0] CtrlOffs       = 32'h10;
    localparam logic [31:0] MtimerWinSize  = 32'h14;

    localparam int unsigned CtrlEnBit    = 0;
    localparam int unsigned CtrlPrescLsb = 8;

    typedef enum logic [2:0] {
        RegMtimeLo,
        RegMtimeHi,
        RegCmpLo,
        RegCmpHi,
        RegCtrl,
        RegNone
    } mtimer_reg_e;

    function automatic logic [31:0] apply_be(input logic [31:0] cur, input logic [31:0] wdata,
                                             input logic [3:0] be);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/zeroheti_mtimer.sv
// RISC-V style machine timer: 64-bit mtime with prescaler, mtimecmp compare and a
// single-cycle-response register bus.
module zeroheti_mtimer
    import zeroheti_pkg::*;
#(
    parameter logic [31:0] BaseAddr   = MtimerBase,
    parameter int unsigned PrescWidth = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        timer_irq_o
);

    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           mtimecmp_q, mtimecmp_d;
    logic [31:0]           snap_q, snap_d;
    logic                  en_q, en_d;
    logic [PrescWidth-1:0] presc_q, presc_d;
    logic [PrescWidth-1:0] cnt_q, cnt_d;
    logic                  rvalid_q, err_q, irq_q;
    logic [31:0]           rdata_q, rdata_d;

    logic [31:0] offset, ctrl_rd, rd_val;
    logic        hit, wr, rd, tick;
    mtimer_reg_e sel;

    assign gnt_o  = req_i;
    // Addresses below the base wrap to a large offset and fall out of the window.
    assign offset = addr_i - BaseAddr;
    assign hit    = (offset < MtimerWinSize) && (addr_i[1:0] == 2'b00);
    assign wr     = req_i && we_i && hit;
    assign rd     = req_i && !we_i && hit;
    assign tick   = en_q && (cnt_q == presc_q);

    always_comb begin
        sel = RegNone;
        if (hit) begin
            case (offset)
                MtimeLoOffs:    sel = RegMtimeLo;
                MtimeHiOffs:    sel = RegMtimeHi;
                MtimecmpLoOffs: sel = RegCmpLo;
                MtimecmpHiOffs: sel = RegCmpHi;
                CtrlOffs:       sel = RegCtrl;
                default:        sel = RegNone;
            endcase
        end
    end

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[CtrlEnBit] = en_q;
        ctrl_rd[CtrlPrescLsb +: PrescWidth] = presc_q;
    end

    always_comb begin
        rd_val = '0;
        case (sel)
            RegMtimeLo: rd_val = mtime_q[31:0];
            RegMtimeHi: rd_val = snap_q;
            RegCmpLo:   rd_val = mtimecmp_q[31:0];
            RegCmpHi:   rd_val = mtimecmp_q[63:32];
            RegCtrl:    rd_val = ctrl_rd;
            default:    rd_val = '0;
        endcase
    end

    always_comb begin
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        snap_d     = snap_q;
        en_d       = en_q;
        presc_d    = presc_q;
        cnt_d      = cnt_q;
        if (en_q) cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (wr) begin
            case (sel)
                // An mtime write overrides that cycle's tick on both halves.
                RegMtimeLo: mtime_d = {mtime_q[63:32], apply_be(mtime_q[31:0], wdata_i, be_i)};
                RegMtimeHi: mtime_d = {apply_be(mtime_q[63:32], wdata_i, be_i), mtime_q[31:0]};
                RegCmpLo:   mtimecmp_d[31:0]  = apply_be(mtimecmp_q[31:0], wdata_i, be_i);
                RegCmpHi:   mtimecmp_d[63:32] = apply_be(mtimecmp_q[63:32], wdata_i, be_i);
                RegCtrl: begin
                    if (be_i[CtrlEnBit/8]) en_d = wdata_i[CtrlEnBit];
                    for (int i = 0; i < PrescWidth; i++) begin
                        if (be_i[(CtrlPrescLsb+i)/8]) presc_d[i] = wdata_i[CtrlPrescLsb+i];
                    end
                    if (en_q && !en_d) cnt_d = '0;
                end
                default: ;
            endcase
        end
        if (rd && sel == RegMtimeLo) snap_d = mtime_q[63:32];
        rdata_d = rd ? rd_val : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            snap_q     <= '0;
            en_q       <= 1'b0;
            presc_q    <= '0;
            cnt_q      <= '0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            snap_q     <= snap_d;
            en_q       <= en_d;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            rvalid_q   <= req_i;
            err_q      <= req_i && !hit;
            rdata_q    <= rdata_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    assign rvalid_o    = rvalid_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_zeroheti_mtimer.sv
// Scoreboard bench for zeroheti_mtimer: directed scenarios plus random bus traffic
// checked against a cycle-level behavioural model.
module tb_zeroheti_mtimer;

    localparam logic [31:0] Base = 32'h0000_A100;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [3:0]  be_i = '0;
    logic        gnt_o, rvalid_o, err_o, timer_irq_o;
    logic [31:0] rdata_o;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    // Reference state
    logic [63:0] m_mtime = '0;
    logic [63:0] m_cmp = '1;
    logic [31:0] m_snap = '0;
    logic        m_en = 1'b0;
    logic [7:0]  m_presc = '0;
    int          m_elapsed = 0;
    logic        m_irq = 1'b0;
    logic [31:0] last_rdata = '0;

    zeroheti_mtimer dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .timer_irq_o (timer_irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic model_step();
        logic [31:0] off, ctrl;
        logic        tick, new_en, irq_next;
        logic [63:0] nt;
        exp_t        e;
        irq_next = (m_mtime >= m_cmp);
        tick     = m_en && (m_elapsed == int'(m_presc));
        nt       = m_mtime + (tick ? 64'd1 : 64'd0);
        new_en   = m_en;
        ctrl     = {16'h0, m_presc, 7'h0, m_en};
        if (req_i) begin
            off     = addr_i - Base;
            e.err   = !((off < 32'h14) && (addr_i[1:0] == 2'b00));
            e.rdata = '0;
            if (!e.err && we_i) begin
                case (off)
                    32'h00: nt = {m_mtime[63:32], lanes(m_mtime[31:0], wdata_i, be_i)};
                    32'h04: nt = {lanes(m_mtime[63:32], wdata_i, be_i), m_mtime[31:0]};
                    32'h08: m_cmp[31:0] = lanes(m_cmp[31:0], wdata_i, be_i);
                    32'h0C: m_cmp[63:32] = lanes(m_cmp[63:32], wdata_i, be_i);
                    default: begin
                        ctrl    = lanes(ctrl, wdata_i, be_i);
                        new_en  = ctrl[0];
                        m_presc = ctrl[15:8];
                    end
                endcase
            end else if (!e.err) begin
                case (off)
                    32'h00: begin
                        e.rdata = m_mtime[31:0];
                        m_snap  = m_mtime[63:32];
                    end
                    32'h04: e.rdata = m_snap;
                    32'h08: e.rdata = m_cmp[31:0];
                    32'h0C: e.rdata = m_cmp[63:32];
                    default: e.rdata = ctrl;
                endcase
            end
            exp_q.push_back(e);
        end
        if (m_en) m_elapsed = tick ? 0 : (m_elapsed + 1) % 256;
        if (m_en && !new_en) m_elapsed = 0;
        m_en    = new_en;
        m_mtime = nt;
        m_irq   = irq_next;
    endtask

    initial forever begin
        @(posedge clk_i or posedge rst_i);
        if (rst_i) begin
            m_mtime = '0; m_cmp = '1; m_snap = '0; m_en = 1'b0;
            m_presc = '0; m_elapsed = 0; m_irq = 1'b0;
            exp_q.delete();
        end else begin
            model_step();
        end
    end

    // Monitor: pops one expectation per response cycle.
    always @(negedge clk_i) begin
        if (rst_i) begin
            check("reset_outputs", {29'b0, rvalid_o, err_o, timer_irq_o, rdata_o}, 64'd0);
        end else begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("rvalid", {63'b0, rvalid_o}, 64'd1);
                check("resp", {31'b0, err_o, rdata_o}, {31'b0, mon_e.err, mon_e.rdata});
                last_rdata = rdata_o;
            end else begin
                check("idle_resp", {31'b0, rvalid_o, err_o, rdata_o}, 64'd0);
            end
            check("irq", {63'b0, timer_irq_o}, {63'b0, m_irq});
        end
    end

    task automatic op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be);
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd; be_i = be;
        #1 check("gnt", {63'b0, gnt_o}, 64'd1);
        @(negedge clk_i);
        req_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic rd_expect(input string name, input logic [31:0] addr,
                             input logic [31:0] val);
        op(1'b0, addr, 32'h0, 4'h0);
        #1 check(name, {32'b0, last_rdata}, {32'b0, val});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        logic [31:0] a, d;
        logic        w;
        int          k;
        idle(2);
        #2 rst_i = 1'b0;
        idle(1);

        rd_expect("ctrl_reset", Base + 32'h10, 32'h0);
        rd_expect("cmphi_reset", Base + 32'h0C, 32'hFFFF_FFFF);

        op(1'b1, Base + 32'h10, 32'h0000_0301, 4'hF);
        idle(40);
        rd_expect("presc3_mtime", Base, 32'd10);

        op(1'b1, Base + 32'h10, 32'h0, 4'hF);
        op(1'b1, Base, 32'hFFFF_FFFE, 4'hF);
        op(1'b1, Base + 32'h04, 32'h0, 4'hF);
        op(1'b1, Base + 32'h10, 32'h1, 4'hF);
        rd_expect("snap_lo", Base, 32'hFFFF_FFFE);
        idle(3);
        rd_expect("snap_hi", Base + 32'h04, 32'h0);

        op(1'b1, Base + 32'h10, 32'h0, 4'hF);
        op(1'b1, Base, 32'h0, 4'hF);
        op(1'b1, Base + 32'h04, 32'h0, 4'hF);
        op(1'b1, Base + 32'h0C, 32'h0, 4'hF);
        op(1'b1, Base + 32'h08, 32'h20, 4'hF);
        op(1'b1, Base + 32'h10, 32'h1, 4'hF);
        idle(40);
        #1 check("irq_high", {63'b0, timer_irq_o}, 64'd1);
        op(1'b1, Base + 32'h0C, 32'hFFFF_FFFF, 4'hF);
        idle(2);
        #1 check("irq_dropped", {63'b0, timer_irq_o}, 64'd0);

        op(1'b0, Base + 32'h14, 32'h0, 4'h0);
        op(1'b1, Base + 32'h02, 32'h1234, 4'hF);
        op(1'b1, Base + 32'h10, 32'h0, 4'hF);
        op(1'b1, Base, 32'h1122_3344, 4'hF);
        op(1'b1, Base, 32'h0000_00AB, 4'b0001);
        rd_expect("byte_lane", Base, 32'h1122_33AB);

        // mtime wrap
        op(1'b1, Base, 32'hFFFF_FFFF, 4'hF);
        op(1'b1, Base + 32'h04, 32'hFFFF_FFFF, 4'hF);
        op(1'b1, Base + 32'h10, 32'h1, 4'hF);
        idle(2);
        op(1'b0, Base, 32'h0, 4'h0);
        op(1'b0, Base + 32'h04, 32'h0, 4'h0);

        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 8);
            case (k)
                0, 1, 2, 3, 4: a = Base + 32'(4 * k);
                5: a = Base + 32'h14;
                6: a = Base + 32'($urandom_range(1, 3));
                7: a = Base - 32'h4;
                default: a = $urandom;
            endcase
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            if (k == 4) d = (d & 32'hFFFF_00FF) | (32'($urandom_range(0, 3)) << 8);
            op(w, a, d, 4'($urandom));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 5)));
        end

        // Reset during an in-flight read
        op(1'b1, Base + 32'h10, 32'h0, 4'hF);
        op(1'b1, Base + 32'h04, 32'h55, 4'hF);
        op(1'b1, Base + 32'h08, 32'h5, 4'hF);
        op(1'b0, Base, 32'h0, 4'h0);
        req_i = 1'b1; we_i = 1'b0; addr_i = Base;
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        req_i = 1'b0;
        idle(2);
        #2 rst_i = 1'b0;
        idle(1);
        rd_expect("rst_snap", Base + 32'h04, 32'h0);
        rd_expect("rst_mtime_lo", Base, 32'h0);
        rd_expect("rst_cmp_lo", Base + 32'h08, 32'hFFFF_FFFF);
        rd_expect("rst_cmp_hi", Base + 32'h0C, 32'hFFFF_FFFF);
        rd_expect("rst_ctrl", Base + 32'h10, 32'h0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/zeroheti_mtimer.md
ZEROHETI_MTIMER -- requirements
Module: zeroheti_mtimer

Interface
REQ-001 SHALL have parameter BaseAddr, default 32'h0000_A100, bus base of the register window (matches mtimer rule in zeroheti_pkg).
REQ-002 SHALL have parameter PrescWidth, default 8, width of the tick prescaler.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_i, input, 1, bus request.
REQ-006 SHALL have port gnt_o, output, 1, grant.
REQ-007 SHALL have port addr_i, input, 32, byte address.
REQ-008 SHALL have port we_i, input, 1, write enable.
REQ-009 SHALL have port be_i, input, 4, byte enables.
REQ-010 SHALL have port wdata_i, input, 32, write data.
REQ-011 SHALL have port rvalid_o, output, 1, response valid.
REQ-012 SHALL have port rdata_o, output, 32, read data.
REQ-013 SHALL have port err_o, output, 1, response error, qualified by rvalid_o.
REQ-014 SHALL have port timer_irq_o, output, 1, machine timer interrupt.

Function
REQ-015 SHALL drive gnt_o = req_i combinationally (always ready, no stall).
REQ-016 SHALL assert rvalid_o exactly one cycle after each granted request, for exactly one cycle; back-to-back requests SHALL yield back-to-back responses.
REQ-017 SHALL decode offset = addr_i - BaseAddr: 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 CTRL (bit0 EN, bits[PrescWidth+7:8] PRESC).
REQ-018 SHALL respond with err_o=1, rdata_o=0 and no state change when offset >= 0x14, offset outside the window, or addr_i[1:0] != 0.
REQ-019 SHALL apply writes per byte lane; lanes with be_i[n]=0 unchanged; unused CTRL bits read 0.
REQ-020 SHALL keep rdata_o at 0 whenever rvalid_o=0 or on write responses.
REQ-021 SHALL hold a PrescWidth-bit prescaler counter; when EN=1 the counter increments each cycle, and on counter == PRESC it SHALL clear and mtime SHALL increment by 1 (PRESC=0: mtime increments every cycle).
REQ-022 SHALL freeze mtime and the prescaler counter when EN=0; writing EN 1->0 SHALL clear the prescaler counter.
REQ-023 SHALL wrap mtime from 64'hFFFF_FFFF_FFFF_FFFF to 0 without error.
REQ-024 SHALL, on a bus write to MTIME_LO or MTIME_HI in the same cycle as a tick, take the written lanes and drop that tick for the whole 64-bit value; writing LO SHALL NOT carry into HI.
REQ-025 SHALL latch mtime[63:32] into a snapshot register on every MTIME_LO read; MTIME_HI reads SHALL return the snapshot, giving atomic LO-then-HI reads.
REQ-026 SHALL compute timer_irq_o as a register updated each cycle to (mtime >= mtimecmp), unsigned 64-bit, one-cycle latency from the compared values.
REQ-027 SHALL return register value as of the request cycle (before that cycle's tick).

Reset
REQ-028 SHALL on rst_i=1 asynchronously set mtime=0, snapshot=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, prescaler=0, rvalid_o=0, err_o=0, rdata_o=0, timer_irq_o=0.
REQ-029 SHALL drop any response pending when reset asserts mid-transaction; no rvalid_o after reset release for a pre-reset request.

Structure
REQ-030 SHALL place register offsets (MtimeLoOffs..CtrlOffs) and the CTRL field positions in zeroheti_pkg beside the address map.
REQ-031 SHALL be a single module with no sub-modules; bus decode and the timer core share one file.

Verification
REQ-032 Reset, then read 0x10, 0x0C -> rdata 0x0, then 0xFFFF_FFFF; timer_irq_o=0.
REQ-033 Write CTRL=0x0000_0301 (PRESC=3, EN=1), wait 40 cycles -> MTIME_LO read returns 10 (+/-0 against model).
REQ-034 Set mtime=0x0000_0000_FFFF_FFFE, EN=1, PRESC=0, read LO then HI across carry -> HI matches snapshot taken at LO read, not live value.
REQ-035 Set MTIMECMP=0x20 with mtime=0, PRESC=0, EN=1 -> timer_irq_o rises exactly 1 cycle after mtime reaches 0x20; writing MTIMECMP_HI=0xFFFF_FFFF drops it next cycle.
REQ-036 Read 0xA114 and write 0xA102 -> err_o=1 with rvalid_o, rdata 0, registers unchanged; write MTIME_LO with be=4'b0001 data 0xAB -> only byte 0 updated.
REQ-037 Assert rst_i the cycle after a granted read -> no rvalid_o, all registers at REQ-028 values.
